// File: rtl/fifo_param.sv
// Parameterised synchronous FIFO with programmable almost-full/almost-empty
// thresholds, overflow/underflow pulses and an optional first-word-fall-through
// read port. Storage is a DEPTH x DATA_W array addressed by wrapping pointers.
module fifo_param #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    parameter int unsigned AE_LEVEL = 2,
    parameter int unsigned FWFT     = 0,
    localparam int unsigned AW      = $clog2(DEPTH),
    localparam int unsigned CW      = AW + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [CW-1:0]     count,
    output logic              overflow,
    output logic              underflow
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              full_w, empty_w;
    logic              wr_acc, rd_acc;

    // Status flags derive only from the registered count.
    assign full_w       = (count_q == CW'(DEPTH));
    assign empty_w      = (count_q == '0);
    assign full         = full_w;
    assign empty        = empty_w;
    assign almost_full  = (count_q >= CW'(AF_LEVEL));
    assign almost_empty = (count_q <= CW'(AE_LEVEL));
    assign count        = count_q;
    assign dout         = dout_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // Next-state for pointers, count, read data and error pulses.
    always_comb begin
        wr_acc      = wr_en && !full_w;
        rd_acc      = rd_en && !empty_w;
        wr_ptr_d    = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d    = rd_acc ? rd_ptr_q + AW'(1) : rd_ptr_q;
        overflow_d  = wr_en && full_w;
        underflow_d = rd_en && empty_w;
        dout_d      = dout_q;

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (FWFT == 0) begin
            if (rd_acc) begin
                dout_d = mem_q[rd_ptr_q];
            end
        end else if (count_d != '0) begin
            // The head slot may be the one being written this edge (FIFO was
            // empty, or held one word that is being read): bypass din.
            if (wr_acc && (rd_ptr_d == wr_ptr_q)) begin
                dout_d = din;
            end else begin
                dout_d = mem_q[rd_ptr_d];
            end
        end
    end

    // Control and read-data registers with asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            dout_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            dout_q      <= dout_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array; contents are left untouched by reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: tb/tb_fifo_param.sv
// Bench for fifo_param: a standard-read and a FWFT instance share stimulus and
// are compared each cycle against a queue-based reference model.
module tb_fifo_param;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       wr_en, rd_en;
    logic [7:0] din;

    logic [7:0] s_dout, f_dout;
    logic       s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic       f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [4:0] s_count, f_count;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state.
    logic [7:0] m_q [$];
    logic [7:0] m_dout_s, m_dout_f;
    logic       m_ovf, m_unf;

    always #5 clk = ~clk;

    fifo_param #(.DATA_W(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)) u_dut_std (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .rd_en(rd_en), .din(din),
        .dout(s_dout), .full(s_full), .empty(s_empty), .almost_full(s_af),
        .almost_empty(s_ae), .count(s_count), .overflow(s_ovf), .underflow(s_unf)
    );

    fifo_param #(.DATA_W(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1)) u_dut_fwft (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .rd_en(rd_en), .din(din),
        .dout(f_dout), .full(f_full), .empty(f_empty), .almost_full(f_af),
        .almost_empty(f_ae), .count(f_count), .overflow(f_ovf), .underflow(f_unf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        int n;
        n = m_q.size();
        check("std_count", 32'(s_count), 32'(n));
        check("std_full", 32'(s_full), 32'(n == 16));
        check("std_empty", 32'(s_empty), 32'(n == 0));
        check("std_af", 32'(s_af), 32'(n >= 14));
        check("std_ae", 32'(s_ae), 32'(n <= 2));
        check("std_ovf", 32'(s_ovf), 32'(m_ovf));
        check("std_unf", 32'(s_unf), 32'(m_unf));
        check("std_dout", 32'(s_dout), 32'(m_dout_s));
        check("fwft_count", 32'(f_count), 32'(n));
        check("fwft_flags", {28'd0, f_full, f_empty, f_af, f_ae},
              {28'd0, n == 16, n == 0, n >= 14, n <= 2});
        check("fwft_pulses", {30'd0, f_ovf, f_unf}, {30'd0, m_ovf, m_unf});
        check("fwft_dout", 32'(f_dout), 32'(m_dout_f));
    endtask

    // One clock edge of the reference behaviour, from the pre-edge occupancy.
    task automatic model_edge(input logic wr, input logic rd, input logic [7:0] d);
        bit was_full, was_empty;
        was_full  = (m_q.size() == 16);
        was_empty = (m_q.size() == 0);
        m_ovf = wr && was_full;
        m_unf = rd && was_empty;
        if (rd && !was_empty) begin
            m_dout_s = m_q[0];
            void'(m_q.pop_front());
        end
        if (wr && !was_full) m_q.push_back(d);
        if (m_q.size() != 0) m_dout_f = m_q[0];
    endtask

    task automatic step(input logic wr, input logic rd, input logic [7:0] d);
        @(negedge clk);
        wr_en = wr;
        rd_en = rd;
        din   = d;
        model_edge(wr, rd, d);
        @(posedge clk);
        #1;
        check_all();
    endtask

    // Asynchronous reset asserted between edges; outputs checked at once.
    task automatic async_reset();
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        #2;
        reset_n = 1'b0;
        m_q.delete();
        m_dout_s = 8'h00;
        m_dout_f = 8'h00;
        m_ovf    = 1'b0;
        m_unf    = 1'b0;
        #1;
        check_all();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    logic [7:0] fill_vals [16] = '{8'd45, 8'd73, 8'd34, 8'd94, 8'd5, 8'd23, 8'd87, 8'd72,
                                   8'd11, 8'd41, 8'd66, 8'd21, 8'd88, 8'd50, 8'd28, 8'd32};

    initial begin
        reset_n = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        din     = 8'h00;
        m_dout_s = 8'h00;
        m_dout_f = 8'h00;
        m_ovf    = 1'b0;
        m_unf    = 1'b0;
        #12;
        check_all();
        @(negedge clk);
        reset_n = 1'b1;

        // Fill to full, then one rejected write.
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, fill_vals[i]);
        check("fill_full", 32'(s_full), 32'd1);
        step(1'b1, 1'b0, 8'd11);
        check("fill_ovf_pulse", 32'(s_ovf), 32'd1);
        check("fill_count_hold", 32'(s_count), 32'd16);

        // Drain in order, then one rejected read.
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 8'h00);
            check("drain_order", 32'(s_dout), 32'(fill_vals[i]));
        end
        step(1'b0, 1'b1, 8'h00);
        check("drain_unf_pulse", 32'(s_unf), 32'd1);
        check("drain_dout_hold", 32'(s_dout), 32'd32);
        step(1'b0, 1'b0, 8'h00);

        // Simultaneous read/write at count 8 across pointer wraps.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'h80 + i));
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 8'(8'hC0 + i));
        check("simul_count", 32'(s_count), 32'd8);

        // Full plus read plus write on the same edge.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'h10 + i));
        step(1'b1, 1'b1, 8'hEE);
        check("full_rw_count", 32'(s_count), 32'd15);
        check("full_rw_ovf", 32'(s_ovf), 32'd1);

        // FWFT fall-through of a single word.
        async_reset();
        step(1'b1, 1'b0, 8'hA5);
        check("fwft_a5", 32'(f_dout), 32'hA5);
        step(1'b0, 1'b1, 8'h00);
        check("fwft_hold", {23'd0, f_empty, f_dout}, {23'd0, 1'b1, 8'hA5});

        // Reset mid-fill at count 9.
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 8'(i + 1));
        async_reset();
        step(1'b1, 1'b0, 8'h3C);
        step(1'b1, 1'b0, 8'h4D);
        step(1'b0, 1'b1, 8'h00);
        check("post_rst_first", 32'(s_dout), 32'h3C);

        // Randomized traffic with phases biased toward full, empty and churn.
        for (int i = 0; i < 3000; i++) begin
            int pw, pr;
            case ((i / 250) % 4)
                0:       begin pw = 80; pr = 30; end
                1:       begin pw = 30; pr = 80; end
                2:       begin pw = 50; pr = 50; end
                default: begin pw = 95; pr = 95; end
            endcase
            step(1'($urandom_range(0, 99) < pw), 1'($urandom_range(0, 99) < pr),
                 8'($urandom));
            if (i == 1700) async_reset();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fifo_param.md
FIFO_PARAM -- requirements
Module: fifo_param

Interface
Parameters:
REQ-001 DATA_W, 8, data word width in bits (>=1).
REQ-002 DEPTH, 16, number of storage words; SHALL be a power of two, >=4.
REQ-003 AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL.
REQ-004 AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL.
REQ-005 FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through.

Ports (CW = clog2(DEPTH)+1):
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 reset_n  in  1  asynchronous, active-low reset.
REQ-008 wr_en  in  1  write request.
REQ-009 rd_en  in  1  read request.
REQ-010 din  in  DATA_W  write data, sampled on a rising edge with wr_en=1.
REQ-011 dout  out  DATA_W  read data.
REQ-012 full  out  1  count == DEPTH.
REQ-013 empty  out  1  count == 0.
REQ-014 almost_full  out  1  count >= AF_LEVEL.
REQ-015 almost_empty  out  1  count <= AE_LEVEL.
REQ-016 count  out  CW  words currently stored, 0..DEPTH.
REQ-017 overflow  out  1  one-cycle pulse: write rejected.
REQ-018 underflow  out  1  one-cycle pulse: read rejected.

Function
REQ-019 Storage: DEPTH x DATA_W array; write and read pointers are CW-1 bits and wrap from DEPTH-1 to 0 without gaps.
REQ-020 Write accepted iff wr_en=1 and full=0 at the edge: din stored at wr_ptr, wr_ptr incremented.
REQ-021 Read accepted iff rd_en=1 and empty=0 at the edge: rd_ptr incremented.
REQ-022 Both accepted on the same edge: count unchanged, both pointers advance; full and empty do not change.
REQ-023 wr_en=1 while full=1: data dropped, storage/pointers/count unchanged, even if a read is accepted on the same edge; overflow=1 for the following cycle.
REQ-024 rd_en=1 while empty=1: pointers/count unchanged, dout unchanged; underflow=1 for the following cycle.
REQ-025 count, full, empty, almost_full, almost_empty are registered or derived from registered state only; all reflect an edge's accepted operations immediately after that edge.
REQ-026 FWFT=0: dout updates one edge after an accepted read with the word at the old rd_ptr (one-cycle latency); otherwise dout holds its last value.
REQ-027 FWFT=1: while empty=0, dout presents the word at rd_ptr with no read request; an accepted read advances to the next word after the edge; a word written into an empty FIFO appears on dout one edge after the write (empty deasserts on that same edge).
REQ-028 FWFT=1 while empty=1: dout holds last presented value.
REQ-029 Data order strictly first-in first-out across any number of pointer wraps.

Reset
REQ-030 reset_n=0 asynchronously forces: pointers=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, dout=0.
REQ-031 Reset mid-operation discards all stored words; array contents need not be cleared.
REQ-032 Release of reset_n takes effect at the next rising edge; requests seen at that edge are processed normally.

Verification (DATA_W=8, DEPTH=16, AF_LEVEL=14, AE_LEVEL=2)
REQ-033 Fill: reset, write 45,73,34,94,5,23,87,72,11,41,66,21,88,50,28,32 -> full=1, count=16, almost_full from count=14; 17th write (11) -> overflow pulse, count stays 16.
REQ-034 Drain FWFT=0: 16 reads after fill -> dout sequence 45..32 in order, each one edge after its read; empty=1 after last; 17th read -> underflow pulse, dout stays 32.
REQ-035 Simultaneous: count=8, wr_en=rd_en=1 for 20 edges -> count stays 8, order preserved across pointer wrap.
REQ-036 Full + read + write same edge -> read accepted, write dropped, overflow=1, count=15.
REQ-037 FWFT=1: write 0xA5 into empty FIFO -> next cycle empty=0, dout=0xA5 without rd_en; read -> empty=1, dout holds 0xA5.
REQ-038 Async reset asserted mid-fill (count=9) between edges -> outputs reach reset values immediately; after release, first read returns first post-reset write.
